// File: rtl/dcache_if.sv
// dcache_if: CPU request/response and line-wide memory handshake bundle for dcache_assoc.
interface dcache_if #(parameter int LINE_W = 512);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic [31:0]       cpu_req_addr;
  logic [31:0]       cpu_req_wdata;
  logic [3:0]        cpu_req_wstrb;
  logic              cpu_resp_valid;
  logic [31:0]       cpu_resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_rdata;
  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/dcache_assoc.sv
// dcache_assoc: set-associative write-back write-allocate data cache with round-robin replacement.
module dcache_assoc #(
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 16
) (
  input logic     clk,
  input logic     rst_n,
  dcache_if.slave bus
);
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int WDW    = $clog2(LINE_WORDS);
  localparam int OW     = WDW + 2;
  localparam int IW     = $clog2(SETS);
  localparam int TW     = 32 - OW - IW;
  localparam int WW     = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RESP      = 3'd1;
  localparam logic [2:0] WB        = 3'd2;
  localparam logic [2:0] FILL_REQ  = 3'd3;
  localparam logic [2:0] FILL_WAIT = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              live_q;
  logic [TW-1:0]     tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [WW-1:0]     rr_q    [SETS];
  logic [TW-1:0]     tag_rq;
  logic [IW-1:0]     idx_q;
  logic [WDW-1:0]    wd_q;
  logic              we_q, use_rr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [WW-1:0]     way_q;

  logic [TW-1:0]     in_tag;
  logic [IW-1:0]     in_idx;
  logic [WDW-1:0]    in_wd;
  logic              unused;
  logic              hit, vic_inv, accept, store_en, fill, wr_en;
  logic [WW-1:0]     hit_way, vic_way, wr_way;
  logic [IW-1:0]     wr_idx;
  logic [LINE_W-1:0] wr_line;

  function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] l, input logic [31:0] d,
                                              input logic [3:0] s, input logic [WDW-1:0] wd);
    merge = l;
    for (int b = 0; b < 4; b++)
      if (s[b]) merge[32 * int'(wd) + 8 * b +: 8] = d[8 * b +: 8];
  endfunction

  assign in_tag = bus.cpu_req_addr[31 -: TW];
  assign in_idx = bus.cpu_req_addr[OW +: IW];
  assign in_wd  = bus.cpu_req_addr[2 +: WDW];
  assign unused = ^bus.cpu_req_addr[1:0];

  // Victim is the lowest invalid way; the descending scan leaves the lowest one last.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_inv = 1'b0;
    vic_way = rr_q[in_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][in_idx] && tag_q[w][in_idx] == in_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[w][in_idx]) begin
        vic_inv = 1'b1;
        vic_way = WW'(w);
      end
    end
  end

  always_comb begin
    accept   = bus.cpu_req_valid && live_q && state_q == IDLE;
    store_en = accept && hit && bus.cpu_req_we;
    fill     = state_q == FILL_WAIT && bus.mem_resp_valid;
    wr_en    = fill || store_en;
    wr_way   = fill ? way_q : hit_way;
    wr_idx   = fill ? idx_q : in_idx;
    wr_line  = fill ? merge(bus.mem_resp_rdata, wdata_q, we_q ? wstrb_q : 4'b0, wd_q)
                    : merge(data_q[hit_way][in_idx], bus.cpu_req_wdata, bus.cpu_req_wstrb, in_wd);
    state_d  = state_q == IDLE     ? (accept ? (hit ? RESP : dirty_q[vic_way][in_idx] ? WB : FILL_REQ) : IDLE) :
               state_q == RESP     ? IDLE :
               state_q == WB       ? (bus.mem_req_ready ? FILL_REQ : WB) :
               state_q == FILL_REQ ? (bus.mem_req_ready ? FILL_WAIT : FILL_REQ) :
                                     (bus.mem_resp_valid ? RESP : FILL_WAIT);
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_way][wr_idx] <= wr_line;
    if (fill) tag_q[way_q][idx_q] <= tag_rq;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      live_q   <= 1'b0;
      tag_rq   <= '0;
      idx_q    <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      use_rr_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      way_q    <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept) begin
        tag_rq   <= in_tag;
        idx_q    <= in_idx;
        wd_q     <= in_wd;
        we_q     <= bus.cpu_req_we;
        wdata_q  <= bus.cpu_req_wdata;
        wstrb_q  <= bus.cpu_req_wstrb;
        way_q    <= hit ? hit_way : vic_way;
        use_rr_q <= !vic_inv;
      end
      if (store_en && |bus.cpu_req_wstrb) dirty_q[hit_way][in_idx] <= 1'b1;
      if (fill) begin
        valid_q[way_q][idx_q] <= 1'b1;
        dirty_q[way_q][idx_q] <= we_q && |wstrb_q;
        if (use_rr_q) rr_q[idx_q] <= WAYS > 1 ? rr_q[idx_q] + 1'b1 : '0;
      end
    end
  end

  assign bus.cpu_req_ready  = live_q && state_q == IDLE;
  assign bus.cpu_resp_valid = state_q == RESP;
  assign bus.cpu_resp_rdata = state_q == RESP ? data_q[way_q][idx_q][{wd_q, 5'b0} +: 32] : '0;
  assign bus.mem_req_valid  = state_q == WB || state_q == FILL_REQ;
  assign bus.mem_req_we     = state_q == WB;
  assign bus.mem_req_addr   = state_q == WB       ? {tag_q[way_q][idx_q], idx_q, {OW{1'b0}}} :
                              state_q == FILL_REQ ? {tag_rq, idx_q, {OW{1'b0}}} : '0;
  assign bus.mem_req_wdata  = state_q == WB ? data_q[way_q][idx_q] : '0;
endmodule
